// File: rtl/pipeline_stall_unit.sv
// Hazard/stall sequencer: load-use freeze, taken-branch flush and the multdiv start/wait FSM.
// Optional perf counters are compiled in when STALL_PERF_EN is defined.
module pipeline_stall_unit #(
    parameter int unsigned MD_TIMEOUT = 34,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             memstall,
    input  logic             DX_mult,
    input  logic             DX_div,
    input  logic             multdiv_ready,
    input  logic             multdiv_except,
    input  logic             X_branch_taken,
    output logic             PC_WE,
    output logic             FD_WE,
    output logic             DX_WE,
    output logic             XM_nop,
    output logic             FD_flush,
    output logic             DX_flush,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic             md_done,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {MdIdle, MdBusy, MdDone} md_state_e;

    md_state_e    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          except_q, except_d;
    logic          timeout_q, timeout_d;
    logic          md_start;
    logic          md_busy;
    logic          freeze;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= MdIdle;
            tcnt_q    <= '0;
            except_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            except_q  <= except_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        except_d  = except_q;
        timeout_d = timeout_q;
        md_start  = 1'b0;
        md_busy   = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        md_done   = 1'b0;
        md_error  = 1'b0;
        unique case (state_q)
            MdIdle: begin
                // A pending load-use hazard defers the start until the operands are valid
                if ((DX_mult || DX_div) && !memstall) begin
                    md_start  = 1'b1;
                    ctrl_MULT = DX_mult;
                    ctrl_DIV  = !DX_mult;
                    state_d   = MdBusy;
                    tcnt_d    = '0;
                    except_d  = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            MdBusy: begin
                md_busy = 1'b1;
                if (multdiv_ready) begin
                    state_d  = MdDone;
                    except_d = multdiv_except;
                    tcnt_d   = '0;
                end else if (tcnt_q == TLAST) begin
                    state_d   = MdDone;
                    timeout_d = 1'b1;
                    tcnt_d    = '0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            MdDone: begin
                // Result is only consumed on the cycle the X instruction actually advances
                if (!memstall) begin
                    md_done   = 1'b1;
                    md_error  = except_q || timeout_q;
                    state_d   = MdIdle;
                    except_d  = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = MdIdle;
        endcase
    end

    assign freeze   = memstall || md_start || md_busy;
    assign PC_WE    = !freeze;
    assign FD_WE    = !freeze;
    assign DX_WE    = !freeze;
    assign XM_nop   = freeze;
    assign FD_flush = X_branch_taken && !freeze;
    assign DX_flush = X_branch_taken && !freeze;

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PC_WE && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (FD_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_unit.sv
// Self-checking bench for pipeline_stall_unit: directed vector table, multdiv corner
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_pipeline_stall_unit;

    localparam int unsigned MD_TIMEOUT = 34;
    localparam int unsigned CNT_W      = 6;
    localparam longint     CNT_MAX    = (64'd1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             memstall = 1'b0, DX_mult = 1'b0, DX_div = 1'b0;
    logic             multdiv_ready = 1'b0, multdiv_except = 1'b0, X_branch_taken = 1'b0;
    logic             PC_WE, FD_WE, DX_WE, XM_nop, FD_flush, DX_flush;
    logic             ctrl_MULT, ctrl_DIV, md_done, md_error;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    pipeline_stall_unit #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .memstall(memstall), .DX_mult(DX_mult),
        .DX_div(DX_div), .multdiv_ready(multdiv_ready), .multdiv_except(multdiv_except),
        .X_branch_taken(X_branch_taken), .PC_WE(PC_WE), .FD_WE(FD_WE), .DX_WE(DX_WE),
        .XM_nop(XM_nop), .FD_flush(FD_flush), .DX_flush(DX_flush), .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV), .md_done(md_done), .md_error(md_error),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    // Output vector order: PC FD DX XM_nop FD_flush DX_flush MULT DIV md_done md_error
    logic [9:0] outv;
    assign outv = {PC_WE, FD_WE, DX_WE, XM_nop, FD_flush, DX_flush,
                   ctrl_MULT, ctrl_DIV, md_done, md_error};

    // Model state: phase 0 idle, 1 waiting for multdiv, 2 result pending
    int     m_phase;
    int     m_since;
    bit     m_err;
    longint m_stall;
    longint m_flush;

    function automatic logic [9:0] model_out();
        bit start, frz, done;
        start = (m_phase == 0) && (DX_mult || DX_div) && !memstall;
        frz   = memstall || start || (m_phase == 1);
        done  = (m_phase == 2) && !memstall;
        return {!frz, !frz, !frz, frz, X_branch_taken && !frz, X_branch_taken && !frz,
                start && DX_mult, start && !DX_mult, done, done && m_err};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_since = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_advance();
        logic [9:0] e;
        e = model_out();
        if (e[6] && m_stall < CNT_MAX) m_stall++;
        if (e[5] && m_flush < CNT_MAX) m_flush++;
        case (m_phase)
            0: if (e[3] || e[2]) begin m_phase = 1; m_since = 1; m_err = 0; end
            1: begin
                if (multdiv_ready) begin
                    m_phase = 2; m_err = multdiv_except;
                end else if (m_since == MD_TIMEOUT) begin
                    m_phase = 2; m_err = 1;
                end else begin
                    m_since++;
                end
            end
            default: if (!memstall) m_phase = 0;
        endcase
    endtask

    task automatic check_vec(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %b, expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_perf(input string name);
`ifdef STALL_PERF_EN
        check_int({name, " stall_cycles"}, longint'(stall_cycles), m_stall);
        check_int({name, " flush_count"}, longint'(flush_count), m_flush);
`else
        check_int({name, " stall_cycles"}, longint'(stall_cycles), 0);
        check_int({name, " flush_count"}, longint'(flush_count), 0);
`endif
    endtask

    // in = {memstall, DX_mult, DX_div, ready, except, branch}
    task automatic drive(input logic [5:0] in);
        {memstall, DX_mult, DX_div, multdiv_ready, multdiv_except, X_branch_taken} = in;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        model_advance();
        #1;
    endtask

    task automatic apply_reset();
        drive(6'b0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic md_run(input string tag, input bit is_div, input int ready_at,
                          input bit exc, input int exp_done_at, input bit exp_err);
        int  pulses, wrong, frozen, done_at;
        bit  err_seen;
        logic op;
        pulses = 0; wrong = 0; frozen = 0; done_at = -1; err_seen = 0;
        for (int c = 0; c < 60 && !(done_at >= 0 && c > done_at + 1); c++) begin
            op = (done_at < 0);
            drive({1'b0, op && !is_div, op && is_div, c == ready_at,
                   (c == ready_at) && exc, 1'b0});
            check_vec({tag, " model"}, outv, model_out());
            if (is_div ? ctrl_DIV : ctrl_MULT) pulses++;
            if (is_div ? ctrl_MULT : ctrl_DIV) wrong++;
            if (!PC_WE) frozen++;
            if (md_done && done_at < 0) begin done_at = c; err_seen = md_error; end
            tick();
        end
        check_int({tag, " start pulses"}, pulses, 1);
        check_int({tag, " wrong pulses"}, wrong, 0);
        check_int({tag, " frozen cycles"}, frozen, exp_done_at);
        check_int({tag, " md_done cycle"}, done_at, exp_done_at);
        check_int({tag, " md_error"}, err_seen, exp_err);
    endtask

    typedef struct packed {
        logic [5:0] in;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{6'b000000, 10'b1110000000};  // idle, free running
        vecs[1]  = '{6'b100001, 10'b0001000000};  // load-use, branch ignored
        vecs[2]  = '{6'b000001, 10'b1110110000};  // branch re-evaluated, flush
        vecs[3]  = '{6'b001000, 10'b0001000100};  // div start pulse
        vecs[4]  = '{6'b001110, 10'b0001000000};  // busy, ready+except
        vecs[5]  = '{6'b100000, 10'b0001000000};  // done held by memstall
        vecs[6]  = '{6'b000000, 10'b1110000011};  // done with error
        vecs[7]  = '{6'b011000, 10'b0001001000};  // mult+div -> mult
        vecs[8]  = '{6'b011000, 10'b0001000000};  // busy, no re-issue
        vecs[9]  = '{6'b011100, 10'b0001000000};  // ready
        vecs[10] = '{6'b000001, 10'b1110110010};  // done, branch flushes
        vecs[11] = '{6'b000100, 10'b1110000000};  // stray ready ignored

        apply_reset();
        drive(6'b0);
        check_vec("reset state", outv, 10'b1110000000);
        check_perf("reset");

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].in);
            check_vec($sformatf("table[%0d]", i), outv, vecs[i].exp);
            check_perf($sformatf("table[%0d]", i));
            tick();
        end

        md_run("mult ready16", 1'b0, 16, 1'b0, 17, 1'b0);
        md_run("div except5", 1'b1, 5, 1'b1, 6, 1'b1);
        md_run("mult timeout", 1'b0, -1, 1'b0, 35, 1'b1);
        md_run("mult ready1", 1'b0, 1, 1'b0, 2, 1'b0);

        // Asynchronous reset while busy drops the operation
        drive(6'b010000);
        check_vec("pre-reset start", outv, 10'b0001001000);
        tick();
        drive(6'b010000);
        tick();
        drive(6'b000000);
        reset = 1'b1;
        model_reset();
        #1;
        check_vec("async reset busy", outv, 10'b1110000000);
        check_perf("async reset");
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(6'b000100);
            check_vec("after reset", outv, 10'b1110000000);
            tick();
        end

        for (int i = 0; i < 400; i++) begin
            drive({($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 1) == 0), ($urandom_range(0, 2) == 0)});
            check_vec("random", outv, model_out());
            check_perf("random");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
